// File: rtl/riscv_dram_requester.sv
// riscv_dram_requester
//   Initiator side of the DRAM wren/rden/mem_ready handshake. On a data-cache
//   miss it optionally writes back a dirty victim block, then reads the fill
//   block. Each enable is held until mem_ready is seen. The fill data is
//   returned with a one-cycle fill_valid pulse. busy stalls the core for the
//   whole transaction. A watchdog aborts any access that DRAM never answers.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   miss_req          1-cycle miss request, only looked at while idle
//   victim_dirty      victim block must be written back before the fill
//   victim_addr/data  writeback address and block
//   fill_addr         refill address
//   busy              transaction in progress
//   fill_valid        1-cycle pulse, fill_data holds the new block
//   fill_data         last refill block, held until the next fill_valid
//   err_timeout       1-cycle pulse, access aborted by the watchdog
//   wren, rden        DRAM write/read enables (levels, never both high)
//   dram_addr         DRAM address, stable while an enable is high
//   dram_wdata        DRAM write data, stable while wren is high
//   dram_rdata        DRAM read data, valid in the mem_ready cycle
//   mem_ready         DRAM completion pulse

module riscv_dram_requester #(
  parameter int ADDR_W      = 64,
  parameter int BLK_W       = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_req,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [BLK_W-1:0]  victim_data,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              busy,
  output logic              fill_valid,
  output logic [BLK_W-1:0]  fill_data,
  output logic              err_timeout,
  output logic              wren,
  output logic              rden,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [BLK_W-1:0]  dram_wdata,
  input  logic [BLK_W-1:0]  dram_rdata,
  input  logic              mem_ready
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    GAP,
    RD,
    DONE
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] fill_addr_q;

  // Single transaction FSM. Every output is a register driven from here.
  // The victim address/data go straight into dram_addr/dram_wdata when the
  // miss is accepted; only the fill address needs its own latch because it
  // is used after the writeback. mem_ready is checked before the watchdog so
  // a completion arriving on the last allowed cycle still counts as success.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      fill_addr_q <= '0;
      busy        <= 1'b0;
      fill_valid  <= 1'b0;
      fill_data   <= '0;
      err_timeout <= 1'b0;
      wren        <= 1'b0;
      rden        <= 1'b0;
      dram_addr   <= '0;
      dram_wdata  <= '0;
    end else begin
      fill_valid  <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            busy        <= 1'b1;
            fill_addr_q <= fill_addr;
            timer       <= '0;
            if (victim_dirty) begin
              wren       <= 1'b1;
              dram_addr  <= victim_addr;
              dram_wdata <= victim_data;
              state      <= WB;
            end else begin
              rden      <= 1'b1;
              dram_addr <= fill_addr;
              state     <= RD;
            end
          end
        end

        WB: begin
          if (mem_ready) begin
            wren  <= 1'b0;
            state <= GAP;
          end else if (timer == TMR_LAST) begin
            wren        <= 1'b0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // One cycle with both enables low so the DRAM model's counter clears
        // between the write and the read.
        GAP: begin
          rden      <= 1'b1;
          dram_addr <= fill_addr_q;
          timer     <= '0;
          state     <= RD;
        end

        RD: begin
          if (mem_ready) begin
            fill_data  <= dram_rdata;
            rden       <= 1'b0;
            fill_valid <= 1'b1;
            state      <= DONE;
          end else if (timer == TMR_LAST) begin
            rden        <= 1'b0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
